objram_arbiter: RTL and testbench

- Sequences all traffic to the single-port 16x32 object RAM that holds the stone/gold/diamond table.
- Three requesters share it: the draw engine, rope player 1 and rope player 2.
- Replaces the ad-hoc `draw_stone_flag`/`second_live` address muxing inside the rope controllers with a registered fixed/round-robin arbiter and an explicit req/gnt/rvalid handshake.
- Sits between the rope controllers, the draw engine and the RAM macro.

---
 rtl/objram_arbiter.sv | 220 ++++++++++++++++++++++
 tb/tb_objram_arbiter.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/objram_arbiter.sv
// objram_arbiter: sequences every access to the single-port 16x32 object RAM
// (stone/gold/diamond table) among the draw engine and the two rope players.
// Draw has fixed top priority; the two ropes share the rest round-robin.
// One access is issued per cycle at most. Reads return one cycle after the
// grant on the matching *_rvalid strobe.
//
// Optional feature macro: OBJRAM_LOCK_EN. When defined, a rope read granted
// with rX_lock=1 takes exclusive rope ownership until that rope's next write
// grant or until it drops rX_lock. This gives an atomic read-modify-write.
// Without the macro the lock inputs are ignored and no lock state exists.
//
// Ports:
//   clock, reset                  - rising-edge clock, synchronous active-high reset
//   draw_req/draw_addr            - draw engine read request
//   draw_rvalid                   - rdata valid for the draw engine
//   rN_req/rN_we/rN_addr/rN_wdata - rope N request (held until rN_gnt)
//   rN_lock                       - rope N exclusive-ownership request
//   rN_gnt                        - one-cycle grant pulse for rope N
//   rN_rvalid                     - rdata valid for rope N
//   rdata                         - shared read data (combinational copy of ram_q)
//   ram_addr/ram_wdata/ram_wren   - registered RAM controls
//   ram_q                         - RAM read port, one-cycle latency
module objram_arbiter #(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              draw_req,
  input  logic [ADDR_W-1:0] draw_addr,
  output logic              draw_rvalid,
  input  logic              r1_req,
  input  logic              r1_we,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [DATA_W-1:0] r1_wdata,
  input  logic              r1_lock,
  output logic              r1_gnt,
  output logic              r1_rvalid,
  input  logic              r2_req,
  input  logic              r2_we,
  input  logic [ADDR_W-1:0] r2_addr,
  input  logic [DATA_W-1:0] r2_wdata,
  input  logic              r2_lock,
  output logic              r2_gnt,
  output logic              r2_rvalid,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_wren,
  input  logic [DATA_W-1:0] ram_q
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] GRANT = 1'b1;

  // Registered state
  logic [0:0]        state;
  logic              last_rope;   // 0 = rope 1 granted last, 1 = rope 2
  logic              iss_draw;    // draw read on the RAM this cycle
  logic              iss_rope;    // rope read on the RAM this cycle
  logic              iss_tag;     // owner of that rope read: 0 = r1, 1 = r2

  // Next-state values
  logic [0:0]        state_d;
  logic              last_rope_d;
  logic              iss_draw_d;
  logic              iss_rope_d;
  logic              iss_tag_d;
  logic              r1_gnt_d;
  logic              r2_gnt_d;
  logic              draw_rvalid_d;
  logic              r1_rvalid_d;
  logic              r2_rvalid_d;
  logic [ADDR_W-1:0] ram_addr_d;
  logic [DATA_W-1:0] ram_wdata_d;
  logic              ram_wren_d;

  // Arbitration terms
  logic              r1_elig;
  logic              r2_elig;
  logic              win_draw;
  logic              win_r1;
  logic              win_r2;

`ifdef OBJRAM_LOCK_EN
  logic              lock_valid;
  logic              lock_owner;  // 0 = r1, 1 = r2
  logic              lock_valid_d;
  logic              lock_owner_d;
  logic              owner_lock;
`else
  logic              unused_lock;
  assign unused_lock = r1_lock ^ r2_lock;
`endif

  // Read data is passed straight through; the rvalid strobes qualify it
  assign rdata = ram_q;

  // Arbitration, issue pipeline and next-state logic
  always_comb begin
    state_d       = IDLE;
    last_rope_d   = last_rope;
    iss_draw_d    = 1'b0;
    iss_rope_d    = 1'b0;
    iss_tag_d     = 1'b0;
    r1_gnt_d      = 1'b0;
    r2_gnt_d      = 1'b0;
    ram_addr_d    = ram_addr;
    ram_wdata_d   = ram_wdata;
    ram_wren_d    = 1'b0;

    // A rope holding req through its grant cycle must not be issued twice
    r1_elig = r1_req & ~r1_gnt;
    r2_elig = r2_req & ~r2_gnt;
`ifdef OBJRAM_LOCK_EN
    lock_valid_d = lock_valid;
    lock_owner_d = lock_owner;
    owner_lock   = lock_owner ? r2_lock : r1_lock;
    if (lock_valid) begin
      if (lock_owner) r1_elig = 1'b0;
      else            r2_elig = 1'b0;
    end
`endif

    // Draw always preempts; a tie between ropes goes to the one not granted last
    win_draw = draw_req;
    win_r1   = ~draw_req & r1_elig & (~r2_elig | last_rope);
    win_r2   = ~draw_req & r2_elig & (~r1_elig | ~last_rope);

    if (win_draw) begin
      state_d    = GRANT;
      ram_addr_d = draw_addr;
      iss_draw_d = 1'b1;
    end else if (win_r1) begin
      state_d     = GRANT;
      r1_gnt_d    = 1'b1;
      last_rope_d = 1'b0;
      ram_addr_d  = r1_addr;
      ram_wdata_d = r1_wdata;
      ram_wren_d  = r1_we;
      iss_rope_d  = ~r1_we;
      iss_tag_d   = 1'b0;
    end else if (win_r2) begin
      state_d     = GRANT;
      r2_gnt_d    = 1'b1;
      last_rope_d = 1'b1;
      ram_addr_d  = r2_addr;
      ram_wdata_d = r2_wdata;
      ram_wren_d  = r2_we;
      iss_rope_d  = ~r2_we;
      iss_tag_d   = 1'b1;
    end

    // Data for the access on the RAM this cycle comes back next cycle
    draw_rvalid_d = iss_draw;
    r1_rvalid_d   = iss_rope & ~iss_tag;
    r2_rvalid_d   = iss_rope & iss_tag;

`ifdef OBJRAM_LOCK_EN
    // Release on the owner's write grant or when it drops its lock request
    if (lock_valid) begin
      if (~owner_lock ||
          (win_r1 & r1_we & ~lock_owner) ||
          (win_r2 & r2_we & lock_owner)) begin
        lock_valid_d = 1'b0;
      end
    end
    // Acquire on a locked read grant
    if (win_r1 & ~r1_we & r1_lock) begin
      lock_valid_d = 1'b1;
      lock_owner_d = 1'b0;
    end else if (win_r2 & ~r2_we & r2_lock) begin
      lock_valid_d = 1'b1;
      lock_owner_d = 1'b1;
    end
`endif
  end

  // State and output registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      last_rope   <= 1'b1;
      iss_draw    <= 1'b0;
      iss_rope    <= 1'b0;
      iss_tag     <= 1'b0;
      r1_gnt      <= 1'b0;
      r2_gnt      <= 1'b0;
      draw_rvalid <= 1'b0;
      r1_rvalid   <= 1'b0;
      r2_rvalid   <= 1'b0;
      ram_addr    <= '0;
      ram_wdata   <= '0;
      ram_wren    <= 1'b0;
`ifdef OBJRAM_LOCK_EN
      lock_valid  <= 1'b0;
      lock_owner  <= 1'b0;
`endif
    end else begin
      state       <= state_d;
      last_rope   <= last_rope_d;
      iss_draw    <= iss_draw_d;
      iss_rope    <= iss_rope_d;
      iss_tag     <= iss_tag_d;
      r1_gnt      <= r1_gnt_d;
      r2_gnt      <= r2_gnt_d;
      draw_rvalid <= draw_rvalid_d;
      r1_rvalid   <= r1_rvalid_d;
      r2_rvalid   <= r2_rvalid_d;
      ram_addr    <= ram_addr_d;
      ram_wdata   <= ram_wdata_d;
      ram_wren    <= ram_wren_d;
`ifdef OBJRAM_LOCK_EN
      lock_valid  <= lock_valid_d;
      lock_owner  <= lock_owner_d;
`endif
    end
  end

endmodule

// File: tb/tb_objram_arbiter.sv
// tb_objram_arbiter: directed bench for objram_arbiter with a behavioural
// single-port RAM and a read scoreboard. Expected reads are queued when the
// request is driven and retired when an rvalid strobe appears.
module tb_objram_arbiter;

  localparam int unsigned ADDR_W = 4;
  localparam int unsigned DATA_W = 32;

  localparam logic [1:0] TAG_DRAW = 2'd0;
  localparam logic [1:0] TAG_R1   = 2'd1;
  localparam logic [1:0] TAG_R2   = 2'd2;

  logic              clock = 1'b0;
  logic              reset;
  logic              draw_req;
  logic [ADDR_W-1:0] draw_addr;
  logic              draw_rvalid;
  logic              r1_req, r1_we, r1_lock, r1_gnt, r1_rvalid;
  logic [ADDR_W-1:0] r1_addr;
  logic [DATA_W-1:0] r1_wdata;
  logic              r2_req, r2_we, r2_lock, r2_gnt, r2_rvalid;
  logic [ADDR_W-1:0] r2_addr;
  logic [DATA_W-1:0] r2_wdata;
  logic [DATA_W-1:0] rdata;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic              ram_wren;
  logic [DATA_W-1:0] ram_q;

  logic [DATA_W-1:0] mem    [16];
  logic [DATA_W-1:0] shadow [16];
  logic [33:0]       exp_q  [$];   // {tag, data}

  int n_checks = 0;
  int n_fails  = 0;

  objram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clock(clock), .reset(reset),
    .draw_req(draw_req), .draw_addr(draw_addr), .draw_rvalid(draw_rvalid),
    .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
    .r1_lock(r1_lock), .r1_gnt(r1_gnt), .r1_rvalid(r1_rvalid),
    .r2_req(r2_req), .r2_we(r2_we), .r2_addr(r2_addr), .r2_wdata(r2_wdata),
    .r2_lock(r2_lock), .r2_gnt(r2_gnt), .r2_rvalid(r2_rvalid),
    .rdata(rdata), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_wren(ram_wren), .ram_q(ram_q)
  );

  always #5 clock = ~clock;

  // Behavioural single-port RAM: write and registered read on the same edge
  always @(posedge clock) begin
    if (ram_wren) mem[ram_addr] <= ram_wdata;
    ram_q <= mem[ram_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic push_exp(input logic [1:0] tag, input logic [3:0] addr);
    exp_q.push_back({tag, shadow[addr]});
  endtask

  // Retire one expectation per rvalid strobe
  always @(negedge clock) begin
    logic [2:0]  vec;
    logic [1:0]  obs_tag;
    logic [33:0] e;
    vec = {r2_rvalid, r1_rvalid, draw_rvalid};
    if (vec != 3'b000) begin
      obs_tag = (vec == 3'b001) ? TAG_DRAW : (vec == 3'b010) ? TAG_R1 :
                (vec == 3'b100) ? TAG_R2 : 2'd3;
      if (exp_q.size() == 0) begin
        chk("rvalid_unexpected", 32'(vec), 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("rvalid_owner", 32'(obs_tag), 32'(e[33:32]));
        chk("rvalid_rdata", rdata, e[31:0]);
      end
    end
  end

  initial begin
    for (int i = 0; i < 16; i++) begin
      shadow[i] = 32'h1000_0000 + 32'(i) * 32'h0011_0101;
    end
    shadow[3] = 32'h0120_180A;
    for (int i = 0; i < 16; i++) mem[i] = shadow[i];

    reset = 1'b1;
    draw_req = 1'b0; draw_addr = '0;
    r1_req = 1'b0; r1_we = 1'b0; r1_addr = '0; r1_wdata = '0; r1_lock = 1'b0;
    r2_req = 1'b0; r2_we = 1'b0; r2_addr = '0; r2_wdata = '0; r2_lock = 1'b0;

    // Reset values
    step();
    chk("rst_r1_gnt", 32'(r1_gnt), 32'd0);
    chk("rst_r2_gnt", 32'(r2_gnt), 32'd0);
    chk("rst_rvalid", 32'({draw_rvalid, r1_rvalid, r2_rvalid}), 32'd0);
    chk("rst_ram_wren", 32'(ram_wren), 32'd0);
    chk("rst_ram_addr", 32'(ram_addr), 32'd0);
    chk("rst_ram_wdata", ram_wdata, 32'd0);
    step();
    reset = 1'b0;

    // Single rope-1 read of addr 3
    r1_req = 1'b1; r1_we = 1'b0; r1_addr = 4'd3;
    push_exp(TAG_R1, 4'd3);
    step();
    chk("t1_r1_gnt", 32'(r1_gnt), 32'd1);
    chk("t1_ram_addr", 32'(ram_addr), 32'd3);
    chk("t1_ram_wren", 32'(ram_wren), 32'd0);
    r1_req = 1'b0;
    step();
    chk("t1_r1_gnt_pulse", 32'(r1_gnt), 32'd0);
    chk("t1_r1_rvalid", 32'(r1_rvalid), 32'd1);
    chk("t1_rdata", rdata, 32'h0120_180A);
    step();

    // Draw streams 0..7 while rope 2 waits
    r2_req = 1'b1; r2_we = 1'b0; r2_addr = 4'd9;
    draw_req = 1'b1;
    for (int i = 0; i < 8; i++) begin
      draw_addr = 4'(i);
      push_exp(TAG_DRAW, 4'(i));
      step();
      chk("t2_r2_held_off", 32'(r2_gnt), 32'd0);
      chk("t2_draw_addr", 32'(ram_addr), 32'(i));
    end
    draw_req = 1'b0;
    push_exp(TAG_R2, 4'd9);
    step();
    chk("t2_r2_gnt", 32'(r2_gnt), 32'd1);
    r2_req = 1'b0;
    step();
    step();
    step();

    // Both ropes held together: grants alternate starting with rope 1
    r1_req = 1'b1; r1_addr = 4'd1; r1_we = 1'b0;
    r2_req = 1'b1; r2_addr = 4'd2; r2_we = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      push_exp((k % 2 == 1) ? TAG_R1 : TAG_R2, (k % 2 == 1) ? 4'd1 : 4'd2);
      step();
      chk("t3_r1_gnt", 32'(r1_gnt), (k % 2 == 1) ? 32'd1 : 32'd0);
      chk("t3_r2_gnt", 32'(r2_gnt), (k % 2 == 1) ? 32'd0 : 32'd1);
    end
    r1_req = 1'b0; r2_req = 1'b0;
    step();
    chk("t3_no_extra_gnt", 32'({r1_gnt, r2_gnt}), 32'd0);
    step();
    step();

    // Rope 2 writes addr 5, then rope 1 reads it back
    r2_req = 1'b1; r2_we = 1'b1; r2_addr = 4'd5; r2_wdata = 32'hDEAD_BEEF;
    step();
    chk("t4_r2_gnt", 32'(r2_gnt), 32'd1);
    chk("t4_ram_wren", 32'(ram_wren), 32'd1);
    chk("t4_ram_addr", 32'(ram_addr), 32'd5);
    chk("t4_ram_wdata", ram_wdata, 32'hDEAD_BEEF);
    shadow[5] = 32'hDEAD_BEEF;
    r2_req = 1'b0; r2_we = 1'b0;
    r1_req = 1'b1; r1_we = 1'b0; r1_addr = 4'd5;
    push_exp(TAG_R1, 4'd5);
    step();
    chk("t4_r1_gnt", 32'(r1_gnt), 32'd1);
    chk("t4_ram_wren_off", 32'(ram_wren), 32'd0);
    chk("t4_no_r2_rvalid", 32'(r2_rvalid), 32'd0);
    r1_req = 1'b0;
    step();
    chk("t4_r1_rvalid", 32'(r1_rvalid), 32'd1);
    step();
    step();

    // Reset in the rope-1 grant cycle kills the in-flight read
    r1_req = 1'b1; r1_we = 1'b0; r1_addr = 4'd3;
    step();
    chk("t5_r1_gnt", 32'(r1_gnt), 32'd1);
    r1_req = 1'b0;
    reset = 1'b1;
    step();
    chk("t5_r1_rvalid_killed", 32'(r1_rvalid), 32'd0);
    chk("t5_gnt_clear", 32'({r1_gnt, r2_gnt, draw_rvalid, r2_rvalid}), 32'd0);
    chk("t5_ram_clear", 32'({ram_wren, 4'(ram_addr)}), 32'd0);
    chk("t5_ram_wdata_clear", ram_wdata, 32'd0);
    reset = 1'b0;
    step();

    // After reset rope 1 wins the first tie again
    r1_req = 1'b1; r1_addr = 4'd7; r2_req = 1'b1; r2_addr = 4'd8;
    push_exp(TAG_R1, 4'd7);
    push_exp(TAG_R2, 4'd8);
    step();
    chk("t6_r1_first", 32'({r1_gnt, r2_gnt}), 32'd2);
    r1_req = 1'b0;
    step();
    chk("t6_r2_second", 32'({r1_gnt, r2_gnt}), 32'd1);
    r2_req = 1'b0;
    step();
    step();
    step();

`ifdef OBJRAM_LOCK_EN
    // Locked read-modify-write by rope 1 holds rope 2 off until the write
    r1_req = 1'b1; r1_we = 1'b0; r1_addr = 4'd6; r1_lock = 1'b1;
    r2_req = 1'b1; r2_we = 1'b0; r2_addr = 4'd6;
    push_exp(TAG_R1, 4'd6);
    step();
    chk("lk_r1_rd_gnt", 32'({r1_gnt, r2_gnt}), 32'd2);
    r1_req = 1'b0;
    step();
    chk("lk_r2_blocked_a", 32'(r2_gnt), 32'd0);
    step();
    chk("lk_r2_blocked_b", 32'(r2_gnt), 32'd0);
    r1_req = 1'b1; r1_we = 1'b1; r1_wdata = 32'h0BAD_F00D;
    step();
    chk("lk_r1_wr_gnt", 32'({r1_gnt, r2_gnt}), 32'd2);
    chk("lk_r1_wr_wren", 32'(ram_wren), 32'd1);
    shadow[6] = 32'h0BAD_F00D;
    push_exp(TAG_R2, 4'd6);
    r1_req = 1'b0; r1_we = 1'b0; r1_lock = 1'b0;
    step();
    chk("lk_r2_gnt_after", 32'(r2_gnt), 32'd1);
    r2_req = 1'b0;
    step();
    step();
    step();
`endif

    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
